// File: rtl/arb_pkg.sv
// Shared defaults and helpers for the arbitrated request buffer.
package arb_pkg;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;

    localparam int unsigned OH_W  = 16;
    localparam int unsigned IDX_W = 4;

    // Index of the lowest set bit; only meaningful for a one-hot input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [OH_W-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = OH_W - 1; i >= 0; i--) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty; pushes while full are dropped.
module sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/arb_req_buffer.sv
// Per-requester queues feeding an external arbiter, with a one-word output register.
// Optional sticky grant-error flag on port err when ARB_REQ_BUFFER_ERR_EN is defined.
module arb_req_buffer
    import arb_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         req,
    output logic                 enable,
    input  logic [N-1:0]         gnt,
    input  logic                 valid,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_id,
`ifdef ARB_REQ_BUFFER_ERR_EN
    output logic                 err,
`endif
    input  logic                 out_ready
);

    localparam int unsigned IW = $clog2(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("arb_req_buffer: N must be 2..16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("arb_req_buffer: DEPTH must be a power of two >= 2");
    end

    logic [N-1:0]  full, empty, pop;
    logic [DW-1:0] fifo_rdata [N];
    logic          gnt_onehot, pop_ok;
    logic [IW-1:0] gnt_idx;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [IW-1:0] out_id_q,    out_id_d;

    for (genvar i = 0; i < N; i++) begin : g_q
        sync_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i]),
            .pop   (pop[i]),
            .wdata (in_data[i*DW +: DW]),
            .rdata (fifo_rdata[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign in_ready  = ~full;
    assign req       = ~empty;
    assign enable    = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

    // A pop needs a clean one-hot grant onto a non-empty queue with room downstream.
    always_comb begin
        gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
        gnt_idx    = IW'(onehot_to_idx(OH_W'(gnt)));
        pop_ok     = valid && enable && gnt_onehot && ((gnt & req) != '0);
        pop        = pop_ok ? gnt : '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (pop_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rdata[gnt_idx];
            out_id_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

`ifdef ARB_REQ_BUFFER_ERR_EN
    logic err_q;

    // Any asserted grant-valid that does not produce a pop is a protocol violation.
    always_ff @(posedge clk) begin
        if (rst)                  err_q <= 1'b0;
        else if (valid && !pop_ok) err_q <= 1'b1;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_arb_req_buffer.sv
// Directed-vector and scoreboard bench for arb_req_buffer (N=4, DW=8, DEPTH=4).
module tb_arb_req_buffer;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    req;
    logic            enable;
    logic [N-1:0]    gnt;
    logic            valid;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_ready;
`ifdef ARB_REQ_BUFFER_ERR_EN
    logic            err;
`endif

    always #5 clk = ~clk;

    arb_req_buffer #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .enable    (enable),
        .gnt       (gnt),
        .valid     (valid),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
`ifdef ARB_REQ_BUFFER_ERR_EN
        .err       (err),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic            rst;
        logic [N-1:0]    in_valid;
        logic [N*DW-1:0] in_data;
        logic [N-1:0]    gnt;
        logic            valid;
        logic            out_ready;
        logic [N-1:0]    req;
        logic [N-1:0]    rdy;
        logic            ov;
        logic [DW-1:0]   od;
        logic [1:0]      oid;
        logic            en;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; in_valid = '0; in_data = '0; gnt = '0; valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] e_req, input logic [N-1:0] e_rdy,
                           input logic e_ov, input logic [DW-1:0] e_od, input logic [1:0] e_id,
                           input logic e_en);
        chk({tag, ".req"},       32'(req),       32'(e_req));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_data"},  32'(out_data),  32'(e_od));
        chk({tag, ".out_id"},    32'(out_id),    32'(e_id));
        chk({tag, ".enable"},    32'(enable),    32'(e_en));
    endtask

    vec_t vt [12];

    logic [DW-1:0] mq [N][$];
    logic          mov;
    logic [DW-1:0] mod;
    logic [1:0]    mid;
    int            rr;

    initial begin
        //           rst iv     data          gnt    v  ordy  req    rdy    ov od     id en
        vt[0]  = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b1};
        vt[1]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b1};
        vt[2]  = '{1'b0, 4'h4, 32'h00A1_0000, 4'h0, 1'b0, 1'b0, 4'h4, 4'hF, 1'b0, 8'h00, 2'd0, 1'b1};
        vt[3]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h4, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 8'hA1, 2'd2, 1'b0};
        vt[4]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 8'hA1, 2'd2, 1'b1};
        vt[5]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h2, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 8'hA1, 2'd2, 1'b1};
        vt[6]  = '{1'b0, 4'h3, 32'h0000_5566, 4'h0, 1'b0, 1'b1, 4'h3, 4'hF, 1'b0, 8'hA1, 2'd2, 1'b1};
        vt[7]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h3, 1'b1, 1'b1, 4'h3, 4'hF, 1'b0, 8'hA1, 2'd2, 1'b1};
        vt[8]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h2, 1'b1, 1'b0, 4'h1, 4'hF, 1'b1, 8'h55, 2'd1, 1'b0};
        vt[9]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b0, 4'h1, 4'hF, 1'b1, 8'h55, 2'd1, 1'b0};
        vt[10] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 8'h66, 2'd0, 1'b1};
        vt[11] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 8'h66, 2'd0, 1'b1};

        idle();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; in_valid = vt[i].in_valid; in_data = vt[i].in_data;
            gnt = vt[i].gnt; valid = vt[i].valid; out_ready = vt[i].out_ready;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].rdy, vt[i].ov, vt[i].od, vt[i].oid, vt[i].en);
`ifdef ARB_REQ_BUFFER_ERR_EN
            chk($sformatf("vec%0d.err", i), 32'(err), (i < 5) ? 32'd0 : 32'd1);
`endif
        end

        // Fill queue 0, then overflow it, then pop while pushing into the full queue.
        idle();
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'h1; in_data = 32'(8'h10 + 8'(k));
            tick();
            chk($sformatf("fill%0d.in_ready0", k), 32'(in_ready[0]), (k < 3) ? 32'd1 : 32'd0);
        end
        in_valid = 4'h1; in_data = 32'h77;
        tick();
        chk("overflow.in_ready", 32'(in_ready), 32'hE);
        chk("overflow.req", 32'(req), 32'h1);
        in_valid = 4'h1; in_data = 32'h88; gnt = 4'h1; valid = 1'b1; out_ready = 1'b1;
        tick();
        chk_all("fullpushpop", 4'h1, 4'hF, 1'b1, 8'h10, 2'd0, 1'b1);
        in_valid = '0; in_data = '0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d.out_data", k), 32'(out_data), 32'(8'h10 + 8'(k)));
            chk($sformatf("drain%0d.out_valid", k), 32'(out_valid), 32'd1);
        end
        chk("drained.req", 32'(req), 32'h0);
        tick();
        chk_all("drained.idle", 4'h0, 4'hF, 1'b0, 8'h13, 2'd0, 1'b1);

        // Simultaneous push and pop on a non-full queue keeps its occupancy.
        idle();
        in_valid = 4'h8; in_data = 32'h3000_0000;
        tick();
        chk("pp.req", 32'(req), 32'h8);
        in_valid = 4'h8; in_data = 32'h3100_0000; gnt = 4'h8; valid = 1'b1; out_ready = 1'b1;
        tick();
        chk_all("pp.pop0", 4'h8, 4'hF, 1'b1, 8'h30, 2'd3, 1'b1);
        in_valid = '0; in_data = '0;
        tick();
        chk_all("pp.pop1", 4'h0, 4'hF, 1'b1, 8'h31, 2'd3, 1'b1);
        gnt = '0; valid = 1'b0;
        tick();
        chk_all("pp.idle", 4'h0, 4'hF, 1'b0, 8'h31, 2'd3, 1'b1);

        // Random traffic against a queue model with round-robin grants.
        mov = 1'b0; mod = 8'h31; mid = 2'd3; rr = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [N-1:0] push_ok;
            logic [N-1:0] e_req, e_rdy;
            int           sel;
            logic         do_pop;

            idle();
            for (int i = 0; i < N; i++) begin
                in_valid[i]        = ($urandom_range(0, 1) == 1);
                in_data[i*DW +: DW] = DW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sel = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (sel < 0 && mq[j].size() > 0) sel = j;
            end
            if (sel >= 0 && $urandom_range(0, 4) != 0) begin
                valid = 1'b1;
                gnt   = N'(1) << sel;
            end
            do_pop = valid && (!mov || out_ready);
            for (int i = 0; i < N; i++) push_ok[i] = in_valid[i] && (mq[i].size() < DEPTH);

            tick();

            if (do_pop) begin
                mod = mq[sel].pop_front();
                mid = 2'(sel);
                mov = 1'b1;
                rr  = (sel + 1) % N;
            end else if (out_ready) begin
                mov = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (push_ok[i]) mq[i].push_back(in_data[i*DW +: DW]);
                e_req[i] = (mq[i].size() > 0);
                e_rdy[i] = (mq[i].size() < DEPTH);
            end
            chk($sformatf("rnd%0d.req", cyc),       32'(req),       32'(e_req));
            chk($sformatf("rnd%0d.in_ready", cyc),  32'(in_ready),  32'(e_rdy));
            chk($sformatf("rnd%0d.out_valid", cyc), 32'(out_valid), 32'(mov));
            chk($sformatf("rnd%0d.out_data", cyc),  32'(out_data),  32'(mod));
            chk($sformatf("rnd%0d.out_id", cyc),    32'(out_id),    32'(mid));
        end

        // Reset mid-stream with traffic still applied: nothing survives, nothing is pushed.
        in_valid = 4'hF; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        valid = 1'b1; gnt = 4'h1; rst = 1'b1;
        tick();
        chk_all("rst_mid", 4'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b1);
        idle();
        tick();
        chk_all("post_rst", 4'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b1);
`ifdef ARB_REQ_BUFFER_ERR_EN
        chk("post_rst.err", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
